// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes / InvSubBytes engine for one 128-bit state.
// Substitutes LANES bytes per cycle in an internal work register.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    input handshake; in_state/in_inv latched on accept
//   in_state[127:0]      byte 0 = [127:120] ... byte 15 = [7:0]
//   in_inv               0 = SubBytes, 1 = InvSubBytes (only when INV_EN=1)
//   out_valid/out_ready  output handshake; out_state held until accepted
//   out_state[127:0]     substituted state (the work register)
//   busy                 engine not idle
module subbytes_iter #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int STEPS = 16 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
    localparam logic INV_B = (INV_EN != 0);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_q, work_d;
    logic               mode_q, mode_d;

    logic [LANES-1:0][7:0] lane_in;
    logic [LANES-1:0][7:0] lane_fwd;
    logic [LANES-1:0][7:0] lane_inv;
    logic [LANES-1:0][7:0] lane_out;
    int                    base;

    // First byte index of the lane group handled this cycle.
    always_comb begin
        base = 0;
        if (STEPS > 1) begin
            base = int'(cnt_q) * LANES;
        end
    end

    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[8*(15 - base - l) +: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_fwd[l] = SBOX[lane_in[l]];

        if (INV_EN != 0) begin : g_inv
            localparam logic [0:255][7:0] ISBOX = {
                128'h52096ad53036a538bf40a39e81f3d7fb,
                128'h7ce339829b2fff87348e4344c4dee9cb,
                128'h547b9432a6c2233dee4c950b42fac34e,
                128'h082ea16628d924b2765ba2496d8bd125,
                128'h72f8f66486689816d4a45ccc5d65b692,
                128'h6c704850fdedb9da5e154657a78d9d84,
                128'h90d8ab008cbcd30af7e45805b8b34506,
                128'hd02c1e8fca3f0f02c1afbd0301138a6b,
                128'h3a9111414f67dcea97f2cfcef0b4e673,
                128'h96ac7422e7ad3585e2f937e81c75df6e,
                128'h47f11a711d29c5896fb7620eaa18be1b,
                128'hfc563e4bc6d279209adbc0fe78cd5af4,
                128'h1fdda8338807c731b11210592780ec5f,
                128'h60517fa919b54a0d2de57a9f93c99cef,
                128'ha0e03b4dae2af5b0c8ebbb3c83539961,
                128'h172b047eba77d626e169146355210c7d
            };
            assign lane_inv[l] = ISBOX[lane_in[l]];
        end else begin : g_no_inv
            // mode_q is tied low here, so this path is never selected.
            assign lane_inv[l] = lane_fwd[l];
        end

        assign lane_out[l] = mode_q ? lane_inv[l] : lane_fwd[l];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_d  = in_state;
                    mode_d  = in_inv & INV_B;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[8*(15 - base - l) +: 8] = lane_out[l];
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_state = work_q;
    assign busy      = (state_q != IDLE);

endmodule
